// File: rtl/image_slideshow_ctrl_pkg.sv
// Shared types and constants for the image slideshow controller:
// FSM encoding, button request codes and default image geometry.
package image_slideshow_ctrl_pkg;

    typedef enum logic {
        SHOW,
        SWITCH
    } state_t;

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_NEXT,
        PEND_PREV
    } pend_t;

    localparam int DEF_IMG_W = 320;
    localparam int DEF_IMG_H = 240;

    function automatic int img_size(input int w, input int h);
        return w * h;
    endfunction

    localparam int IMG_SIZE = img_size(DEF_IMG_W, DEF_IMG_H);

endpackage

// File: rtl/image_slideshow_ctrl_addr_gen.sv
// Registered ROM address generator: base + (y/2)*IMG_W + (x/2), built with
// constant shifts and adds so no general multiplier is inferred.
module image_addr_gen #(
    parameter int ADDS_WIDTH = 18,
    parameter int IMG_W      = 320
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDS_WIDTH-1:0] base,
    input  logic [9:0]            x_pixel,
    input  logic [9:0]            y_pixel,
    input  logic                  drawn_en,
    output logic [ADDS_WIDTH-1:0] rom_addr,
    output logic                  rom_rd_en
);

    logic [9:0]            row;
    logic [9:0]            col;
    logic [ADDS_WIDTH-1:0] row_offset;

    assign row = y_pixel >> 1;
    assign col = x_pixel >> 1;

    // One shifted copy of the row per set bit of IMG_W (320 = 256 + 64).
    always_comb begin
        row_offset = '0;
        for (int i = 0; i < ADDS_WIDTH; i++) begin
            if (IMG_W[i]) begin
                row_offset = row_offset + (ADDS_WIDTH'(row) << i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr  <= '0;
            rom_rd_en <= 1'b0;
        end else begin
            rom_rd_en <= drawn_en;
            if (drawn_en) begin
                rom_addr <= base + row_offset + ADDS_WIDTH'(col);
            end
        end
    end

endmodule

// File: rtl/image_slideshow_ctrl.sv
// Slideshow sequencer: picks the displayed image from button requests or a
// frame timer, switching only in the cycle after frame_start.
module image_slideshow_ctrl
    import image_slideshow_ctrl_pkg::*;
#(
    parameter int ADDS_WIDTH       = 18,
    parameter int IMG_W            = DEF_IMG_W,
    parameter int IMG_H            = DEF_IMG_H,
    parameter int NUM_IMAGES       = 3,
    parameter int FRAMES_PER_IMAGE = 120,
    parameter int IDX_WIDTH        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            x_pixel,
    input  logic [9:0]            y_pixel,
    input  logic                  drawn_en,
    input  logic                  frame_start,
    input  logic                  btn_next,
    input  logic                  btn_prev,
    input  logic                  auto_en,
    output logic [ADDS_WIDTH-1:0] rom_addr,
    output logic                  rom_rd_en,
    output logic [IDX_WIDTH-1:0]  image_idx
);

    localparam int CNT_W = $clog2(FRAMES_PER_IMAGE + 1);
    localparam logic [ADDS_WIDTH-1:0] STEP      = ADDS_WIDTH'(img_size(IMG_W, IMG_H));
    localparam logic [ADDS_WIDTH-1:0] LAST_BASE = ADDS_WIDTH'((NUM_IMAGES - 1) * img_size(IMG_W, IMG_H));
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(NUM_IMAGES - 1);
    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(FRAMES_PER_IMAGE - 1);

    state_t                state, state_next;
    pend_t                 pending, pending_next;
    pend_t                 dir, dir_next;
    pend_t                 req, eff;
    logic                  press;
    logic [CNT_W-1:0]      frame_cnt, frame_cnt_next;
    logic [IDX_WIDTH-1:0]  idx, idx_next;
    logic [ADDS_WIDTH-1:0] base, base_next;

    assign image_idx = idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SHOW;
            pending   <= PEND_NONE;
            dir       <= PEND_NONE;
            frame_cnt <= '0;
            idx       <= '0;
            base      <= '0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            dir       <= dir_next;
            frame_cnt <= frame_cnt_next;
            idx       <= idx_next;
            base      <= base_next;
        end
    end

    // A press in the frame_start cycle itself is honoured by that switch.
    always_comb begin
        state_next     = state;
        pending_next   = pending;
        dir_next       = dir;
        frame_cnt_next = frame_cnt;
        idx_next       = idx;
        base_next      = base;
        press          = btn_next ^ btn_prev;
        req            = btn_next ? PEND_NEXT : PEND_PREV;
        eff            = press ? req : pending;

        case (state)
            SHOW: begin
                if (press) begin
                    pending_next = req;
                end
                if (frame_start) begin
                    if (eff != PEND_NONE) begin
                        state_next = SWITCH;
                        dir_next   = eff;
                    end else if (auto_en && frame_cnt == LAST_CNT) begin
                        state_next = SWITCH;
                        dir_next   = PEND_NEXT;
                    end else begin
                        frame_cnt_next = auto_en ? frame_cnt + 1'b1 : '0;
                    end
                end
            end
            SWITCH: begin
                state_next     = SHOW;
                frame_cnt_next = '0;
                pending_next   = press ? req : PEND_NONE;
                if (dir == PEND_NEXT) begin
                    idx_next  = (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    base_next = (idx == LAST_IDX) ? '0 : base + STEP;
                end else if (dir == PEND_PREV) begin
                    idx_next  = (idx == '0) ? LAST_IDX : idx - 1'b1;
                    base_next = (idx == '0) ? LAST_BASE : base - STEP;
                end
            end
            default: state_next = SHOW;
        endcase
    end

    image_addr_gen #(
        .ADDS_WIDTH (ADDS_WIDTH),
        .IMG_W      (IMG_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .base      (base),
        .x_pixel   (x_pixel),
        .y_pixel   (y_pixel),
        .drawn_en  (drawn_en),
        .rom_addr  (rom_addr),
        .rom_rd_en (rom_rd_en)
    );

endmodule

// File: tb/tb_image_slideshow_ctrl.sv
// Scoreboard bench for image_slideshow_ctrl with a two-frame auto period:
// each driven cycle pushes the expected post-edge outputs, a monitor pops them.
module tb_image_slideshow_ctrl;
    import image_slideshow_ctrl_pkg::*;

    localparam int FPI = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  x_pixel = '0;
    logic [9:0]  y_pixel = '0;
    logic        drawn_en = 1'b0;
    logic        frame_start = 1'b0;
    logic        btn_next = 1'b0;
    logic        btn_prev = 1'b0;
    logic        auto_en = 1'b0;
    logic [17:0] rom_addr;
    logic        rom_rd_en;
    logic [1:0]  image_idx;

    typedef struct {
        int  addr;
        bit  rd;
        int  idx;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    int   mIdx = 0;
    int   mCnt = 0;
    int   mPend = 0;
    int   mDir = 0;
    bit   mSwitch = 0;
    int   expAddr = 0;
    bit   expRd = 0;

    image_slideshow_ctrl #(
        .ADDS_WIDTH       (18),
        .IMG_W            (320),
        .IMG_H            (240),
        .NUM_IMAGES       (3),
        .FRAMES_PER_IMAGE (FPI),
        .IDX_WIDTH        (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x_pixel     (x_pixel),
        .y_pixel     (y_pixel),
        .drawn_en    (drawn_en),
        .frame_start (frame_start),
        .btn_next    (btn_next),
        .btn_prev    (btn_prev),
        .auto_en     (auto_en),
        .rom_addr    (rom_addr),
        .rom_rd_en   (rom_rd_en),
        .image_idx   (image_idx)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference model: 1 = next, 2 = prev; base is idx*IMG_SIZE directly.
    task automatic applyStimulus(input int x, input int y, input bit drawn, input bit fs,
                                 input bit bn, input bit bp);
        exp_t e;
        bit   press;
        int   req;
        int   eff;
        @(negedge clk);
        x_pixel     = 10'(x);
        y_pixel     = 10'(y);
        drawn_en    = drawn;
        frame_start = fs;
        btn_next    = bn;
        btn_prev    = bp;
        if (drawn) begin
            expAddr = mIdx * IMG_SIZE + (y / 2) * 320 + (x / 2);
        end
        expRd = drawn;
        press = bn ^ bp;
        req   = bn ? 1 : 2;
        if (mSwitch) begin
            mIdx    = (mDir == 1) ? (mIdx + 1) % 3 : (mIdx + 2) % 3;
            mCnt    = 0;
            mSwitch = 0;
            mPend   = press ? req : 0;
        end else begin
            if (press) mPend = req;
            if (fs) begin
                eff = mPend;
                if (eff != 0) begin
                    mDir    = eff;
                    mSwitch = 1;
                end else if (auto_en && mCnt == FPI - 1) begin
                    mDir    = 1;
                    mSwitch = 1;
                end else begin
                    mCnt = auto_en ? mCnt + 1 : 0;
                end
            end
        end
        e.addr = expAddr;
        e.rd   = expRd;
        e.idx  = mIdx;
        sb.push_back(e);
    endtask

    task automatic frameStart();
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic drawFew();
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(639, 479, 1, 0, 0, 0);
        applyStimulus(321, 100, 1, 0, 0, 0);
    endtask

    task automatic resetModel();
        mIdx = 0; mCnt = 0; mPend = 0; mDir = 0; mSwitch = 0;
        expAddr = 0; expRd = 0;
        sb.delete();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("rom_addr", 32'(rom_addr), 32'(e.addr));
                checkOutput("rom_rd_en", 32'(rom_rd_en), 32'(e.rd));
                checkOutput("image_idx", 32'(image_idx), 32'(e.idx));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset values
        rst = 1'b1;
        #1;
        checkOutput("reset rom_addr", 32'(rom_addr), 0);
        checkOutput("reset rom_rd_en", 32'(rom_rd_en), 0);
        checkOutput("reset image_idx", 32'(image_idx), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        resetModel();

        // First pixel and far corner at image 0, then blanking holds address
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(639, 479, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(5, 7, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus($urandom_range(639), $urandom_range(479), 1, 0, 0, 0);
        end

        // Auto advance every two frames, wrapping 2 -> 0
        auto_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            frameStart();
            drawFew();
        end

        // Prev at index 0 applies only at frame_start, wrapping to 2
        auto_en = 1'b0;
        frameStart();
        applyStimulus(10, 10, 1, 0, 0, 1);
        drawFew();
        frameStart();
        drawFew();

        // Simultaneous presses cancel; manual beats auto expiry with one step
        applyStimulus(20, 20, 1, 0, 1, 1);
        frameStart();
        drawFew();
        auto_en = 1'b1;
        frameStart();
        applyStimulus(30, 30, 1, 0, 1, 0);
        frameStart();
        drawFew();
        frameStart();
        drawFew();
        frameStart();
        drawFew();
        auto_en = 1'b0;
        applyStimulus(40, 40, 1, 0, 1, 0);
        frameStart();
        drawFew();

        // Reset mid-frame with a pending next at a non-zero index
        applyStimulus(50, 60, 1, 0, 1, 0);
        applyStimulus(52, 60, 1, 0, 0, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        x_pixel = '0; y_pixel = '0; drawn_en = 1'b0;
        frame_start = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
        #1;
        checkOutput("midreset rom_addr", 32'(rom_addr), 0);
        checkOutput("midreset rom_rd_en", 32'(rom_rd_en), 0);
        checkOutput("midreset image_idx", 32'(image_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        resetModel();
        frameStart();
        drawFew();
        frameStart();

        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("scoreboard drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
